// File: rtl/decoder_iter_sched_pkg.sv
//============================================================================
// Module      : decoder_iter_sched_pkg
// Description : Shared constants for the min-sum decoder iteration scheduler.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package decoder_iter_sched_pkg;

    localparam int c_n_iter_def = 5;

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_vn_go    = 4'd1;
    localparam logic [3:0] c_st_vn_wait  = 4'd2;
    localparam logic [3:0] c_st_cn_go    = 4'd3;
    localparam logic [3:0] c_st_cn_wait  = 4'd4;
    localparam logic [3:0] c_st_chk      = 4'd5;
    localparam logic [3:0] c_st_out_go   = 4'd6;
    localparam logic [3:0] c_st_out_wait = 4'd7;
    localparam logic [3:0] c_st_hold     = 4'd8;

    // Counter width able to hold the value n_iter itself.
    function automatic int iter_width(input int n_iter);
        return (n_iter < 1) ? 1 : $clog2(n_iter + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_wdog.sv
//============================================================================
// Module      : decoder_wdog
// Description : Cycle watchdog; expire is high on the TMO_CYC-th enabled cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module decoder_wdog #(
    parameter int TMO_CYC = 255,
    parameter int TMO_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMO_W-1:0] c_last = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != c_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = enable && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/decoder_iter_sched.sv
//============================================================================
// Module      : decoder_iter_sched
// Description : Sequences VN/CN layer passes, syndrome checks and output layer.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module decoder_iter_sched
    import decoder_iter_sched_pkg::*;
#(
    parameter int N_ITER     = c_n_iter_def,
    parameter int ITER_W     = iter_width(N_ITER),
    parameter int EARLY_TERM = 1,
    parameter int TMO_CYC    = 255,
    parameter int TMO_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              llr_loaded,
    input  logic              vn_done,
    input  logic              cn_done,
    input  logic              syn_valid,
    input  logic              syn_zero,
    input  logic              out_done,
    input  logic              dec_ack,
    output logic              load_ready,
    output logic              vn_start,
    output logic              cn_start,
    output logic              first_iter,
    output logic              out_start,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              dec_valid,
    output logic              early_term,
    output logic [ITER_W-1:0] iters_used,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam logic [ITER_W-1:0] c_iter_last = ITER_W'(N_ITER - 1);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [ITER_W-1:0] w_iter_nxt;
    logic [ITER_W-1:0] r_iters_used;
    logic [ITER_W-1:0] w_used_nxt;
    logic              r_early_term;
    logic              w_et_nxt;
    logic              w_timeout;
    logic              w_waiting;
    logic              w_expire;

    logic r_load_ready, r_vn_start, r_cn_start, r_first_iter, r_out_start;
    logic r_dec_valid, r_err_overrun, r_err_timeout;

    assign w_waiting = (r_state == c_st_vn_wait) || (r_state == c_st_cn_wait) ||
                       (r_state == c_st_chk)     || (r_state == c_st_out_wait);

    decoder_wdog #(
        .TMO_CYC (TMO_CYC),
        .TMO_W   (TMO_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_state_nxt != r_state),
        .enable (w_waiting),
        .expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_iter_nxt  = r_iter_cnt;
        w_used_nxt  = r_iters_used;
        w_et_nxt    = r_early_term;
        w_timeout   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (llr_loaded) begin
                    w_state_nxt = c_st_vn_go;
                    w_iter_nxt  = '0;
                    w_et_nxt    = 1'b0;
                end
            end
            c_st_vn_go:  w_state_nxt = c_st_vn_wait;
            c_st_vn_wait: begin
                if (vn_done)       w_state_nxt = c_st_cn_go;
                else if (w_expire) begin
                    w_state_nxt = c_st_idle;
                    w_timeout   = 1'b1;
                end
            end
            c_st_cn_go:  w_state_nxt = c_st_cn_wait;
            c_st_cn_wait: begin
                if (cn_done)       w_state_nxt = c_st_chk;
                else if (w_expire) begin
                    w_state_nxt = c_st_idle;
                    w_timeout   = 1'b1;
                end
            end
            c_st_chk: begin
                if (syn_valid) begin
                    if ((syn_zero && (EARLY_TERM != 0)) || (r_iter_cnt == c_iter_last)) begin
                        w_state_nxt = c_st_out_go;
                        w_used_nxt  = r_iter_cnt + 1'b1;
                        w_et_nxt    = syn_zero && (EARLY_TERM != 0);
                    end else begin
                        w_state_nxt = c_st_vn_go;
                        w_iter_nxt  = r_iter_cnt + 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_nxt = c_st_idle;
                    w_timeout   = 1'b1;
                end
            end
            c_st_out_go: w_state_nxt = c_st_out_wait;
            c_st_out_wait: begin
                if (out_done)      w_state_nxt = c_st_hold;
                else if (w_expire) begin
                    w_state_nxt = c_st_idle;
                    w_timeout   = 1'b1;
                end
            end
            c_st_hold: begin
                if (dec_ack) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_st_idle;
            r_iter_cnt    <= '0;
            r_iters_used  <= '0;
            r_early_term  <= 1'b0;
            r_load_ready  <= 1'b0;
            r_vn_start    <= 1'b0;
            r_cn_start    <= 1'b0;
            r_first_iter  <= 1'b0;
            r_out_start   <= 1'b0;
            r_dec_valid   <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_iter_cnt    <= w_iter_nxt;
            r_iters_used  <= w_used_nxt;
            r_early_term  <= w_et_nxt;
            r_load_ready  <= (w_state_nxt == c_st_idle);
            r_vn_start    <= (w_state_nxt == c_st_vn_go);
            r_cn_start    <= (w_state_nxt == c_st_cn_go);
            r_first_iter  <= (w_state_nxt == c_st_vn_go) && (w_iter_nxt == '0);
            r_out_start   <= (w_state_nxt == c_st_out_go);
            r_dec_valid   <= (w_state_nxt == c_st_hold);
            r_err_overrun <= llr_loaded && (r_state != c_st_idle);
            r_err_timeout <= w_timeout;
        end
    end

    assign load_ready  = r_load_ready;
    assign vn_start    = r_vn_start;
    assign cn_start    = r_cn_start;
    assign first_iter  = r_first_iter;
    assign out_start   = r_out_start;
    assign iter_cnt    = r_iter_cnt;
    assign dec_valid   = r_dec_valid;
    assign early_term  = r_early_term;
    assign iters_used  = r_iters_used;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_decoder_iter_sched.sv
//============================================================================
// Module      : tb_decoder_iter_sched
// Description : Directed self-checking bench for decoder_iter_sched.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_decoder_iter_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic llr_loaded = 1'b0;
    logic dec_ack = 1'b0;
    logic en_cn = 1'b1;
    int   zero_at = 0;

    // DUT A: EARLY_TERM=1
    logic vn_done_a = 0, cn_done_a = 0, syn_valid_a = 0, syn_zero_a = 0, out_done_a = 0;
    logic load_ready_a, vn_start_a, cn_start_a, first_iter_a, out_start_a;
    logic dec_valid_a, early_term_a, err_overrun_a, err_timeout_a;
    logic [2:0] iter_cnt_a, iters_used_a;
    // DUT B: EARLY_TERM=0, acknowledges immediately
    logic vn_done_b = 0, cn_done_b = 0, syn_valid_b = 0, syn_zero_b = 0, out_done_b = 0;
    logic load_ready_b, vn_start_b, cn_start_b, first_iter_b, out_start_b;
    logic dec_valid_b, early_term_b, err_overrun_b, err_timeout_b;
    logic [2:0] iter_cnt_b, iters_used_b;

    int total = 0, bad = 0, cyc = 0;
    int vn_cd_a = 0, cn_cd_a = 0, out_cd_a = 0, syn_idx_a = 0;
    int vn_cd_b = 0, cn_cd_b = 0, out_cd_b = 0, syn_idx_b = 0;
    bit syn_pend_a = 0, syn_pend_b = 0;
    int n_vn = 0, n_cn = 0, n_first = 0, n_out = 0, n_dv = 0, n_to = 0, n_ovr = 0;
    int t_cn = 0, t_to = 0;
    bit b_seen = 0, b_et = 0;
    int b_iters = 0;

    always #5 clk = ~clk;

    decoder_iter_sched #(.N_ITER(5), .ITER_W(3), .EARLY_TERM(1), .TMO_CYC(255), .TMO_W(8)) dut_a (
        .clk(clk), .rst(rst), .llr_loaded(llr_loaded), .vn_done(vn_done_a), .cn_done(cn_done_a),
        .syn_valid(syn_valid_a), .syn_zero(syn_zero_a), .out_done(out_done_a), .dec_ack(dec_ack),
        .load_ready(load_ready_a), .vn_start(vn_start_a), .cn_start(cn_start_a),
        .first_iter(first_iter_a), .out_start(out_start_a), .iter_cnt(iter_cnt_a),
        .dec_valid(dec_valid_a), .early_term(early_term_a), .iters_used(iters_used_a),
        .err_overrun(err_overrun_a), .err_timeout(err_timeout_a));

    decoder_iter_sched #(.N_ITER(5), .ITER_W(3), .EARLY_TERM(0), .TMO_CYC(255), .TMO_W(8)) dut_b (
        .clk(clk), .rst(rst), .llr_loaded(llr_loaded), .vn_done(vn_done_b), .cn_done(cn_done_b),
        .syn_valid(syn_valid_b), .syn_zero(syn_zero_b), .out_done(out_done_b), .dec_ack(1'b1),
        .load_ready(load_ready_b), .vn_start(vn_start_b), .cn_start(cn_start_b),
        .first_iter(first_iter_b), .out_start(out_start_b), .iter_cnt(iter_cnt_b),
        .dec_valid(dec_valid_b), .early_term(early_term_b), .iters_used(iters_used_b),
        .err_overrun(err_overrun_b), .err_timeout(err_timeout_b));

    // Layer models: done 4 cycles after start, syndrome 1 cycle after cn_done.
    always @(negedge clk) begin
        cyc++;
        vn_done_a = 0; cn_done_a = 0; syn_valid_a = 0; syn_zero_a = 0; out_done_a = 0;
        vn_done_b = 0; cn_done_b = 0; syn_valid_b = 0; syn_zero_b = 0; out_done_b = 0;
        if (!rst) begin
            vn_cd_a = 0; cn_cd_a = 0; out_cd_a = 0; syn_pend_a = 0;
            vn_cd_b = 0; cn_cd_b = 0; out_cd_b = 0; syn_pend_b = 0;
        end else begin
            if (syn_pend_a) begin syn_pend_a = 0; syn_valid_a = 1; syn_idx_a++; syn_zero_a = (syn_idx_a == zero_at); end
            if (syn_pend_b) begin syn_pend_b = 0; syn_valid_b = 1; syn_idx_b++; syn_zero_b = (syn_idx_b == zero_at); end
            if (vn_cd_a != 0) begin vn_cd_a--; if (vn_cd_a == 0) vn_done_a = 1; end
            if (vn_cd_b != 0) begin vn_cd_b--; if (vn_cd_b == 0) vn_done_b = 1; end
            if (cn_cd_a != 0) begin cn_cd_a--; if (cn_cd_a == 0) begin cn_done_a = en_cn; syn_pend_a = en_cn; end end
            if (cn_cd_b != 0) begin cn_cd_b--; if (cn_cd_b == 0) begin cn_done_b = en_cn; syn_pend_b = en_cn; end end
            if (out_cd_a != 0) begin out_cd_a--; if (out_cd_a == 0) out_done_a = 1; end
            if (out_cd_b != 0) begin out_cd_b--; if (out_cd_b == 0) out_done_b = 1; end
            if (vn_start_a) vn_cd_a = 4;
            if (vn_start_b) vn_cd_b = 4;
            if (cn_start_a) cn_cd_a = 4;
            if (cn_start_b) cn_cd_b = 4;
            if (out_start_a) out_cd_a = 2;
            if (out_start_b) out_cd_b = 2;
        end
        if (vn_start_a) n_vn++;
        if (vn_start_a && first_iter_a) n_first++;
        if (cn_start_a) begin n_cn++; t_cn = cyc; end
        if (out_start_a) n_out++;
        if (dec_valid_a) n_dv++;
        if (err_timeout_a) begin n_to++; t_to = cyc; end
        if (err_overrun_a) n_ovr++;
        if (dec_valid_b) begin b_seen = 1; b_iters = int'(iters_used_b); b_et = early_term_b; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_cnt();
        n_vn = 0; n_cn = 0; n_first = 0; n_out = 0; n_dv = 0; n_to = 0; n_ovr = 0;
        syn_idx_a = 0; syn_idx_b = 0; b_seen = 0;
    endtask

    task automatic start_frame();
        @(negedge clk) llr_loaded = 1'b1;
        @(negedge clk) llr_loaded = 1'b0;
    endtask

    task automatic wait_dv(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (dec_valid_a) break;
            @(negedge clk);
        end
        chk(tag, dec_valid_a, 1);
    endtask

    initial begin
        int hi;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_load_ready", load_ready_a, 0);
        chk("rst_vn_start", vn_start_a, 0);
        chk("rst_dec_valid", dec_valid_a, 0);
        chk("rst_iter_cnt", iter_cnt_a, 0);
        chk("rst_iters_used", iters_used_a, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_load_ready", load_ready_a, 1);

        // Full N_ITER run, no zero syndrome
        clr_cnt(); zero_at = 0;
        start_frame();
        wait_dv("t1_dv_wait");
        chk("t1_vn", n_vn, 5);
        chk("t1_cn", n_cn, 5);
        chk("t1_first", n_first, 1);
        chk("t1_out", n_out, 1);
        chk("t1_iters_used", iters_used_a, 5);
        chk("t1_early_term", early_term_a, 0);
        chk("t1_iter_cnt", iter_cnt_a, 4);
        dec_ack = 1'b1;
        @(negedge clk) dec_ack = 1'b0;
        chk("t1_dv_drop", dec_valid_a, 0);
        repeat (20) @(negedge clk);

        // Early termination on the 2nd syndrome; DUT B must run all iterations
        clr_cnt(); zero_at = 2;
        start_frame();
        wait_dv("t2_dv_wait");
        chk("t2_vn", n_vn, 2);
        chk("t2_cn", n_cn, 2);
        chk("t2_out", n_out, 1);
        chk("t2_iters_used", iters_used_a, 2);
        chk("t2_early_term", early_term_a, 1);
        dec_ack = 1'b1;
        @(negedge clk) dec_ack = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b_seen) break;
            @(negedge clk);
        end
        chk("t2_b_seen", b_seen, 1);
        chk("t2_b_iters_used", b_iters, 5);
        chk("t2_b_early_term", b_et, 0);
        repeat (20) @(negedge clk);

        // Hold dec_valid for 10 cycles before ack
        clr_cnt(); zero_at = 0;
        start_frame();
        wait_dv("t3_dv_wait");
        hi = 1;
        repeat (9) begin
            @(negedge clk);
            hi += int'(dec_valid_a);
        end
        chk("t3_hold_cycles", hi, 10);
        dec_ack = 1'b1;
        @(negedge clk) dec_ack = 1'b0;
        chk("t3_dv_drop", dec_valid_a, 0);
        chk("t3_load_ready", load_ready_a, 1);
        repeat (20) @(negedge clk);

        // cn_done never arrives: watchdog
        clr_cnt(); en_cn = 1'b0;
        start_frame();
        for (int i = 0; i < 400; i++) begin
            if (err_timeout_a) break;
            @(negedge clk);
        end
        chk("t4_timeout_seen", err_timeout_a, 1);
        chk("t4_idle", load_ready_a, 1);
        repeat (3) @(negedge clk);
        chk("t4_timeout_lat", t_to - t_cn, 256);
        chk("t4_timeout_cnt", n_to, 1);
        chk("t4_no_dv", n_dv, 0);
        chk("t4_vn", n_vn, 1);
        en_cn = 1'b1;
        repeat (20) @(negedge clk);

        // Overrun during VN_WAIT, then reset mid CN_WAIT
        clr_cnt(); zero_at = 0;
        start_frame();
        for (int i = 0; i < 10; i++) begin
            if (vn_start_a) break;
            @(negedge clk);
        end
        @(negedge clk) llr_loaded = 1'b1;
        @(negedge clk) llr_loaded = 1'b0;
        chk("t5_overrun", err_overrun_a, 1);
        for (int i = 0; i < 20; i++) begin
            if (cn_start_a) break;
            @(negedge clk);
        end
        chk("t5_cn_start", cn_start_a, 1);
        @(negedge clk);
        chk("t5_iter_cnt", iter_cnt_a, 0);
        chk("t5_vn", n_vn, 1);
        chk("t5_ovr_cnt", n_ovr, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_load_ready", load_ready_a, 0);
        chk("t5_rst_cn_start", cn_start_a, 0);
        chk("t5_rst_dv", dec_valid_a, 0);
        chk("t5_rst_ovr", err_overrun_a, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rel_load_ready", load_ready_a, 1);
        repeat (10) @(negedge clk);
        chk("t5_no_out", n_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decoder_iter_sched.md
Name: decoder_iter_sched

Overview:
- Iteration scheduler for the neural min-sum decoder.
- Sits between the LLR loader and the variable-node, check-node and output layers.
- Once a full LLR frame is captured, it sequences N_ITER (VN, CN) layer passes, checks the syndrome after each pass, starts the output layer, then holds the decoded word until the consumer acknowledges it.
- Also detects loader overrun and hung layers (watchdog).

Parameters:
N_ITER, 5, maximum decoding iterations (>=1)
ITER_W, 3, width of iteration counters; must satisfy 2**ITER_W > N_ITER
EARLY_TERM, 1, 1 = stop after any iteration whose syndrome is zero
TMO_CYC, 255, maximum cycles spent in any *_WAIT state before a timeout (>=1)
TMO_W, 8, watchdog counter width; must satisfy 2**TMO_W > TMO_CYC

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
llr_loaded  in  1  1-cycle pulse: loader holds a complete frame
vn_done  in  1  VN layer pass finished (1-cycle pulse)
cn_done  in  1  CN layer pass finished (1-cycle pulse)
syn_valid  in  1  syndrome result valid (1-cycle pulse)
syn_zero  in  1  syndrome all-zero; sampled only with syn_valid
out_done  in  1  output layer finished (1-cycle pulse)
dec_ack  in  1  consumer accepted the decoded word
load_ready  out  1  scheduler idle; loader may present a frame
vn_start  out  1  1-cycle start pulse to the VN layer
cn_start  out  1  1-cycle start pulse to the CN layer
first_iter  out  1  VN pass uses channel LLRs only; valid while vn_start=1
out_start  out  1  1-cycle start pulse to the output layer
iter_cnt  out  ITER_W  current iteration index, 0-based
dec_valid  out  1  decoded word available; held until dec_ack
early_term  out  1  current result ended on a zero syndrome; valid with dec_valid
iters_used  out  ITER_W  iterations executed (1..N_ITER); valid with dec_valid
err_overrun  out  1  1-cycle pulse: llr_loaded arrived outside IDLE
err_timeout  out  1  1-cycle pulse: watchdog expired

Behaviour:
- All outputs are registered, Moore-decoded from the state, counters and flags.
- Reset: state IDLE, iter_cnt=0, iters_used=0, watchdog=0.
  - All outputs are 0 except load_ready, which is 1 one cycle after the reset edge.
  - Reset mid-operation aborts immediately; no pulses are emitted.
- States and transitions:
  - IDLE: load_ready=1. llr_loaded -> VN_GO, clear iter_cnt, clear early_term.
  - VN_GO: vn_start=1, first_iter=(iter_cnt==0); always -> VN_WAIT.
  - VN_WAIT: vn_done -> CN_GO.
  - CN_GO: cn_start=1; always -> CN_WAIT.
  - CN_WAIT: cn_done -> CHK.
  - CHK, on syn_valid:
    - syn_zero && EARLY_TERM -> OUT_GO, early_term=1.
    - else if iter_cnt==N_ITER-1 -> OUT_GO.
    - else iter_cnt+1 -> VN_GO.
    - On leaving CHK toward OUT_GO, iters_used = iter_cnt+1.
  - OUT_GO: out_start=1; always -> OUT_WAIT.
  - OUT_WAIT: out_done -> HOLD.
  - HOLD: dec_valid=1. dec_ack -> IDLE. If dec_ack is already high on HOLD entry, dec_valid is high exactly 1 cycle.
- Latency: llr_loaded to the first vn_start is 1 cycle.
- Overhead per iteration is 3 cycles of scheduler state (VN_GO, CN_GO, CHK with syn_valid) plus the layer latencies.
- Done, syn_valid and dec_ack inputs arriving in non-matching states are ignored.
- Watchdog:
  - Counter clears on entry to VN_WAIT, CN_WAIT, CHK and OUT_WAIT; it increments each cycle spent in those states.
  - When it reaches TMO_CYC without the awaited event: err_timeout pulses, go to IDLE, no dec_valid.
  - An awaited event in the same cycle as expiry wins; no error is raised.
- Overrun: llr_loaded while state!=IDLE pulses err_overrun the next cycle; operation continues unaffected.
- llr_loaded coincident with reset is lost.

Decomposition:
- Shared decoder package holds:
  - the state encoding (IDLE..HOLD, 4 bits)
  - the default N_ITER
  - the ITER_W width function (clog2-based)
- Watchdog is a natural sub-module: decoder_wdog.
  - Inputs: clear, enable.
  - Output: expire pulse.
  - Parameter: TMO_CYC.

Test Plan:
- N_ITER=5, syn_zero=0 always, layers answer done 4 cycles after start -> 5 vn_start and 5 cn_start, first_iter only on the first; dec_valid with iters_used=5, early_term=0.
- syn_zero=1 on the 2nd syn_valid -> exactly 2 VN/CN passes, out_start once, iters_used=2, early_term=1. With EARLY_TERM=0 the same stimulus gives iters_used=5.
- dec_ack held low 10 cycles in HOLD -> dec_valid stays 1 for 10 cycles, drops the cycle after ack; load_ready returns 1.
- cn_done never arrives, TMO_CYC=255 -> err_timeout pulses once 255 cycles into CN_WAIT, state IDLE, dec_valid never asserted.
- llr_loaded pulsed during VN_WAIT -> err_overrun pulse, iteration count unaffected. Then rst=0 for 1 cycle mid-CN_WAIT -> all outputs 0, load_ready=1 after release.
